// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver with built-in baud tick generator and 16x oversampling.
// Emits a one-cycle valid pulse per good byte and a one-cycle frame-error pulse.
module uart_rx_unit #(
  parameter int N           = 8,
  parameter int COUNT       = 131,
  parameter int COUNT_TICKS = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_rx,
  output logic [N-1:0] o_data,
  output logic         o_valid,
  output logic         o_frame_err,
  output logic         o_started,
  output logic [3:0]   o_state,
  output logic         o_tick
);

  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int TW = (COUNT_TICKS > 1) ? $clog2(COUNT_TICKS) : 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [CW-1:0] BAUD_LAST = CW'(COUNT - 1);
  localparam logic [TW-1:0] T_HALF    = TW'(COUNT_TICKS / 2 - 1);
  localparam logic [TW-1:0] T_FULL    = TW'(COUNT_TICKS - 1);
  localparam logic [BW-1:0] B_LAST    = BW'(N - 1);

  logic [CW-1:0] baud_q, baud_d;
  logic          tick;
  logic          rx_meta_q, rx_s_q;
  logic [1:0]    state_q, state_d;
  logic [3:0]    state_oh_q, state_oh_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [N-1:0]  sreg_q, sreg_d;
  logic [N-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  assign tick   = (baud_q == BAUD_LAST);
  assign baud_d = tick ? '0 : baud_q + CW'(1);

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    sreg_d  = sreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          tcnt_d  = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (tcnt_q == T_HALF) begin
            tcnt_d  = '0;
            bcnt_d  = '0;
            state_d = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tcnt_q == T_FULL) begin
            tcnt_d = '0;
            sreg_d = {rx_s_q, sreg_q[N-1:1]};
            if (bcnt_q == B_LAST) begin
              state_d = S_STOP;
            end else begin
              bcnt_d = bcnt_q + BW'(1);
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (tcnt_q == T_FULL) begin
            tcnt_d  = '0;
            state_d = S_IDLE;
            if (rx_s_q) begin
              data_d  = sreg_q;
              valid_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One-hot view is registered from the next state so it tracks state_q exactly
  assign state_oh_d = 4'b0001 << state_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      baud_q     <= '0;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= S_IDLE;
      state_oh_q <= 4'b0001;
      tcnt_q     <= '0;
      bcnt_q     <= '0;
      sreg_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      baud_q     <= baud_d;
      rx_meta_q  <= i_rx;
      rx_s_q     <= rx_meta_q;
      state_q    <= state_d;
      state_oh_q <= state_oh_d;
      tcnt_q     <= tcnt_d;
      bcnt_q     <= bcnt_d;
      sreg_q     <= sreg_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  assign o_tick      = tick;
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_started   = (state_q != S_IDLE);
  assign o_state     = state_oh_q;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Bench for uart_rx_unit: random 8N1 traffic against a frame-level
// model that predicts one event (byte or frame error) per frame sent.
module tb_uart_rx_unit;

  localparam int CNT = 7;
  localparam int BIT = 16 * CNT;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_rx  = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_started;
  logic [3:0] o_state;
  logic       o_tick;

  uart_rx_unit #(.N(8), .COUNT(CNT), .COUNT_TICKS(16)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_started   (o_started),
    .o_state     (o_state),
    .o_tick      (o_tick)
  );

  always #25 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Event = {is_frame_err, o_data seen at the pulse}
  logic [8:0] obs_q[$];
  logic [8:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  logic       prev_v = 1'b0;
  logic       prev_e = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_valid) begin
        chk("valid_width", {31'b0, prev_v}, 32'd0);
        chk("valid_and_ferr", {31'b0, o_frame_err}, 32'd0);
        obs_q.push_back({1'b0, o_data});
      end
      if (o_frame_err) begin
        chk("ferr_width", {31'b0, prev_e}, 32'd0);
        obs_q.push_back({1'b1, o_data});
      end
    end
    prev_v <= o_valid;
    prev_e <= o_frame_err;
  end

  task automatic drive(input logic v, input int n);
    i_rx = v;
    repeat (n) @(negedge i_clk);
  endtask

  // A bad stop bit is held low only part of a bit, so the receiver's
  // re-armed start check after the error lands on an idle-high line.
  task automatic send_frame(input logic [7:0] b, input bit ok);
    if (ok) begin
      exp_q.push_back({1'b0, b});
      last_good = b;
    end else begin
      exp_q.push_back({1'b1, last_good});
    end
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) begin
      drive(b[i], BIT / 2);
      if (i == 3) begin
        chk("mid_state", {28'b0, o_state}, 32'h4);
        chk("mid_started", {31'b0, o_started}, 32'd1);
      end
      drive(b[i], BIT - BIT / 2);
    end
    if (ok) begin
      drive(1'b1, BIT);
    end else begin
      drive(1'b0, BIT * 5 / 8);
      drive(1'b1, BIT * 2);
    end
  endtask

  task automatic compare_events(input string tag);
    int n;
    repeat (BIT) @(negedge i_clk);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_event"}, {23'b0, obs_q[i]}, {23'b0, exp_q[i]});
    end
    chk({tag, "_idle"}, {28'b0, o_state}, 32'h1);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_tick && n < 4 * CNT);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, {28'b0, o_state}, 32'h1);
    chk({tag, "_data"}, {24'b0, o_data}, 32'h0);
    chk({tag, "_valid"}, {31'b0, o_valid}, 32'd0);
    chk({tag, "_ferr"}, {31'b0, o_frame_err}, 32'd0);
    chk({tag, "_started"}, {31'b0, o_started}, 32'd0);
    chk({tag, "_tick"}, {31'b0, o_tick}, 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] b;
    bit ok;

    i_rst = 1'b1;
    i_rx  = 1'b1;
    repeat (20) @(negedge i_clk);
    check_reset_outputs("reset");
    i_rst = 1'b0;

    wait_tick(n);
    for (int k = 0; k < 4; k++) begin
      wait_tick(n);
      chk("tick_period", n, CNT);
    end

    send_frame(8'h09, 1'b1);
    compare_events("single");

    send_frame(8'h07, 1'b1);
    send_frame(8'h52, 1'b1);
    send_frame(8'hA5, 1'b1);
    compare_events("b2b");

    drive(1'b0, BIT / 4);
    drive(1'b1, BIT * 2);
    chk("false_start_state", {28'b0, o_state}, 32'h1);
    send_frame(8'h0D, 1'b1);
    compare_events("false_start");

    send_frame(8'h3C, 1'b0);
    chk("ferr_keeps_data", {24'b0, o_data}, 32'h0D);
    send_frame(8'h0A, 1'b1);
    compare_events("frame_err");

    drive(1'b0, BIT);
    drive(1'b1, 4 * BIT + BIT / 2);
    i_rst = 1'b1;
    i_rx  = 1'b1;
    last_good = 8'h00;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("mid_reset");
    i_rst = 1'b0;
    drive(1'b1, BIT);
    send_frame(8'h11, 1'b1);
    compare_events("after_reset");

    for (int f = 0; f < 20; f++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(b, ok);
      if ($urandom_range(0, 1) == 1) drive(1'b1, $urandom_range(1, 3 * BIT));
    end
    compare_events("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
